mant_div_seq: RTL and testbench
===============================

# mant_div_seq

Sequential restoring mantissa divider for the FPU DIV path: the inverse of the MUL-path array multiplier. It accepts two normalized mantissas (hidden bit included) and produces one quotient bit per clock, MSB first. It returns a quotient with guard bits plus a sticky flag for the rounding stage. Exponent and sign handling stay in the DIV top level; this block is the iterative mantissa core behind a Start/Done handshake.

## Interface
- WIDTH, 24: mantissa width including hidden bit (24 single, 53 double).
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- Start  input  1  request; sampled only in IDLE.
- Dividend  input  WIDTH  normalized mantissa, MSB = 1.
- Divisor  input  WIDTH  normalized mantissa, MSB = 1; all-zero flags divide-by-zero.
- Busy  output  1  high whenever state ≠ IDLE.
- Done  output  1  one-cycle pulse; results valid.
- Quotient  output  WIDTH+2  bit WIDTH+1 = integer bit, remaining WIDTH+1 bits fractional.
- Sticky  output  1  final remainder non-zero.
- DivZero  output  1  Divisor was zero.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: on Start=1, latch Divisor into D, load remainder R (WIDTH+1 bits) = {0, Dividend}, clear Quotient and counter.
  - If Divisor = 0: set DivZero=1, Quotient = all ones, Sticky=0, go to DONE.
  - Otherwise go to RUN.
- RUN performs N = WIDTH+2 iterations:
  - diff = R − {0, D}.
  - If no borrow: q=1, R ← diff<<1. Else: q=0, R ← R<<1.
  - Quotient ← {Quotient[WIDTH:0], q}; counter++.
  - After the N-th iteration go to DONE.
- DONE: Done=1 for one cycle. Sticky = (R ≠ 0). Next state IDLE.
- Quotient, Sticky and DivZero hold until the next accepted Start.
- Start while Busy is ignored; inputs are not re-sampled.
- Remainder invariant: R < 2·D always, so WIDTH+1 bits suffice and there is no overflow.
- Quotient range (0.5, 2). Normalization shift and rounding are downstream, not here.
- Reset (any time, including mid-RUN): state=IDLE; Busy=0, Done=0, Quotient=0, Sticky=0, DivZero=0, counter=0, R=0, D=0. The operation in flight is abandoned with no Done.

## Timing
- Start sampled at edge E0 (IDLE → RUN). Iterations occur at edges E1..EN. Edge EN moves the FSM to DONE.
- Done is visible from edge EN to EN+1, i.e. 26 cycles after the Start edge for WIDTH=24. The next Start can be accepted at edge EN+2.
- Divide-by-zero: Done is visible in the cycle directly after E0.
- Busy rises after E0 and falls after the DONE cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- MANT_DIV_STICKY_EN defined: Sticky is computed as the OR-reduction of the final remainder, registered in DONE.
- Not defined: Sticky is tied to 0, the OR-reduction logic is removed, and the downstream rounder truncates.
- All other behaviour is identical in both builds.

## Structure
- Shared package fpu_div_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - default mantissa width constants 24/53;
  - iteration-count function N = WIDTH+2;
  - counter width $clog2(N+1).
- One sub-module, mant_sub: WIDTH+1-bit ripple subtractor built from the FA cell chain with inverted subtrahend and carry-in 1. Outputs Diff and Borrow (= NOT carry-out). It is instantiated once for the per-cycle trial subtraction.

## Test plan
- 1.0/1.0: Dividend=Divisor=24'h800000 → Done 26 cycles after Start, Quotient=26'h2000000, Sticky=0, DivZero=0.
- 1.5/1.0: Dividend=24'hC00000, Divisor=24'h800000 → Quotient=26'h3000000, Sticky=0.
- 1.0/1.5: Dividend=24'h800000, Divisor=24'hC00000 → Quotient=26'h1555555, Sticky=1 (0 with MANT_DIV_STICKY_EN undefined).
- Divide-by-zero: Divisor=0, Dividend=24'h800000 → Done one cycle after Start, DivZero=1, Quotient=26'h3FFFFFF, Sticky=0.
- Start pulsed mid-RUN with different operands → ignored; the first result (1.5/1.0) completes unchanged at cycle 26.
- RST_N low at iteration 10 → Busy=0 and all outputs 0 immediately, no Done. A fresh 1.0/1.0 after release completes correctly.

Source files
------------

// File: rtl/fpu_div_pkg.sv
// ---------------------------------------------------------------------------
// fpu_div_pkg
// Shared definitions for the FPU divide path.
//   - state_e        : FSM states of the iterative mantissa divider
//   - MANT_W_SINGLE  : mantissa width incl. hidden bit, single precision
//   - MANT_W_DOUBLE  : mantissa width incl. hidden bit, double precision
//   - iterCount()    : number of quotient bits produced (integer bit, the
//                      WIDTH-1 fraction bits and two guard bits)
//   - cntWidth()     : width of an iteration counter that can hold iterCount()
// ---------------------------------------------------------------------------
package fpu_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MANT_W_SINGLE = 24;
  localparam int MANT_W_DOUBLE = 53;

  // One iteration per quotient bit; the quotient carries WIDTH+2 bits.
  function automatic int iterCount(input int width);
    return width + 2;
  endfunction

  // Enough bits to represent 0..iterCount(width).
  function automatic int cntWidth(input int width);
    return $clog2(iterCount(width) + 1);
  endfunction

endpackage

// File: rtl/mant_sub.sv
// ---------------------------------------------------------------------------
// mant_sub
// Ripple-carry subtractor used for the trial subtraction of the restoring
// divider. Computes A - B as A + ~B + 1 through a chain of full-adder cells.
// Ports:
//   A      input  W  minuend
//   B      input  W  subtrahend
//   Diff   output W  A - B (modulo 2^W)
//   Borrow output 1  high when B > A (inverse of the final carry-out)
// ---------------------------------------------------------------------------
module mant_sub #(
  parameter int W = 25
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] Diff,
  output logic         Borrow
);

  logic [W:0]   carry;
  logic [W-1:0] bInv;

  // Two's-complement subtraction: invert the subtrahend and inject a
  // carry of one at the LSB of the adder chain.
  assign bInv     = ~B;
  assign carry[0] = 1'b1;

  // Each stage is a plain full-adder cell; the chain ripples LSB to MSB.
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign Diff[i]    = A[i] ^ bInv[i] ^ carry[i];
    assign carry[i+1] = (A[i] & bInv[i]) | (A[i] & carry[i]) | (bInv[i] & carry[i]);
  end

  // No carry out of the top means the subtraction wrapped, i.e. a borrow.
  assign Borrow = ~carry[W];

endmodule

// File: rtl/mant_div_seq.sv
// ---------------------------------------------------------------------------
// mant_div_seq
// Sequential restoring mantissa divider. Produces one quotient bit per clock,
// MSB first, for two normalized mantissas (hidden bit included). The result
// carries one integer bit, WIDTH+1 fraction bits and an optional sticky flag
// for the downstream rounder.
//
// Build option:
//   MANT_DIV_STICKY_EN  defined   : Sticky = OR of the final remainder
//                       undefined : Sticky tied low, rounder truncates
//
// Ports:
//   CLK       input  1        rising-edge clock
//   RST_N     input  1        asynchronous active-low reset
//   Start     input  1        request, only looked at in IDLE
//   Dividend  input  WIDTH    normalized mantissa (MSB = 1)
//   Divisor   input  WIDTH    normalized mantissa, all-zero = divide by zero
//   Busy      output 1        FSM not in IDLE
//   Done      output 1        one-cycle pulse, results valid
//   Quotient  output WIDTH+2  bit WIDTH+1 is the integer bit
//   Sticky    output 1        final remainder non-zero
//   DivZero   output 1        divisor was zero
// ---------------------------------------------------------------------------
module mant_div_seq
  import fpu_div_pkg::*;
#(
  parameter int WIDTH = MANT_W_SINGLE
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH+1:0] Quotient,
  output logic             Sticky,
  output logic             DivZero
);

  localparam int N  = iterCount(WIDTH);
  localparam int CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH+1:0] quo_q, quo_d;
  logic             done_q, done_d;
  logic             sticky_q, sticky_d;
  logic             divzero_q, divzero_d;

  logic [WIDTH:0]   trialDiff;
  logic             trialBorrow;
  logic             stickyCalc;

  // Trial subtraction R - {0, D}. The remainder invariant R < 2D keeps
  // both operands inside WIDTH+1 bits.
  mant_sub #(
    .W (WIDTH + 1)
  ) u_sub (
    .A      (rem_q),
    .B      ({1'b0, div_q}),
    .Diff   (trialDiff),
    .Borrow (trialBorrow)
  );

`ifdef MANT_DIV_STICKY_EN
  // Inexact-result detection: any bit left in the final remainder.
  assign stickyCalc = |rem_d;
`else
  assign stickyCalc = 1'b0;
`endif

  // Next-state logic for the FSM and the datapath registers. Sticky is
  // captured on the same edge that enters DONE so it is valid together
  // with the Done pulse. After the subtract (or restore) the remainder is
  // below D, so the left shift never drops a set MSB.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    div_d     = div_q;
    quo_d     = quo_q;
    done_d    = 1'b0;
    sticky_d  = sticky_q;
    divzero_d = divzero_q;

    case (state_q)
      IDLE: begin
        if (Start) begin
          div_d    = Divisor;
          rem_d    = {1'b0, Dividend};
          quo_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
          if (Divisor == '0) begin
            divzero_d = 1'b1;
            quo_d     = '1;
            done_d    = 1'b1;
            state_d   = DONE;
          end else begin
            divzero_d = 1'b0;
            state_d   = RUN;
          end
        end
      end

      RUN: begin
        if (trialBorrow) begin
          rem_d = rem_q << 1;
        end else begin
          rem_d = trialDiff << 1;
        end
        quo_d = {quo_q[WIDTH:0], ~trialBorrow};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          done_d   = 1'b1;
          sticky_d = stickyCalc;
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      quo_q     <= '0;
      done_q    <= 1'b0;
      sticky_q  <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      quo_q     <= quo_d;
      done_q    <= done_d;
      sticky_q  <= sticky_d;
      divzero_q <= divzero_d;
    end
  end

  assign Busy     = (state_q != IDLE);
  assign Done     = done_q;
  assign Quotient = quo_q;
  assign Sticky   = sticky_q;
  assign DivZero  = divzero_q;

endmodule

// File: tb/tb_mant_div_seq.sv
// ---------------------------------------------------------------------------
// tb_mant_div_seq
// Directed self-checking bench for mant_div_seq at WIDTH = 24. Each scenario
// task drives its own stimulus and compares against hand-computed values.
// Build option MANT_DIV_STICKY_EN selects the expected sticky result.
// ---------------------------------------------------------------------------
module tb_mant_div_seq;

  localparam int W = 24;

  logic           clk;
  logic           rstN;
  logic           start;
  logic [W-1:0]   dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [W+1:0]   quotient;
  logic           sticky;
  logic           divZero;

  int checks;
  int failures;

`ifdef MANT_DIV_STICKY_EN
  localparam logic STICKY_THIRD = 1'b1;
`else
  localparam logic STICKY_THIRD = 1'b0;
`endif

  mant_div_seq #(
    .WIDTH (W)
  ) dut (
    .CLK      (clk),
    .RST_N    (rstN),
    .Start    (start),
    .Dividend (dividend),
    .Divisor  (divisor),
    .Busy     (busy),
    .Done     (done),
    .Quotient (quotient),
    .Sticky   (sticky),
    .DivZero  (divZero)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one Start pulse; returns 1 ns after the accepting edge E0.
  task automatic applyStimulus(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait for Done, counting edges after E0; lat = -1 on timeout.
  task automatic waitDone(output int lat);
    lat = -1;
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    #12;
    checks++;
    if ({busy, done, quotient, sticky, divZero} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b q=%h st=%b dz=%b, want all zero",
               busy, done, quotient, sticky, divZero);
    end
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_one_by_one();
    int lat;
    applyStimulus(24'h800000, 24'h800000);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_after_start: got %b want 1", busy);
    end
    waitDone(lat);
    checks++;
    if (lat !== 26) begin
      failures++;
      $display("[TB] FAIL latency_1_1: got %0d want 26", lat);
    end
    checks++;
    if (quotient !== 26'h2000000 || sticky !== 1'b0 || divZero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL result_1_1: got q=%h st=%b dz=%b want q=2000000 st=0 dz=0",
               quotient, sticky, divZero);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL done_pulse_end: got done=%b busy=%b want 0 0", done, busy);
    end
    checks++;
    if (quotient !== 26'h2000000) begin
      failures++;
      $display("[TB] FAIL quotient_hold: got %h want 2000000", quotient);
    end
  endtask

  task automatic test_one_half_by_one();
    int lat;
    applyStimulus(24'hC00000, 24'h800000);
    waitDone(lat);
    checks++;
    if (lat !== 26 || quotient !== 26'h3000000 || sticky !== 1'b0) begin
      failures++;
      $display("[TB] FAIL result_1p5_1: got lat=%0d q=%h st=%b want lat=26 q=3000000 st=0",
               lat, quotient, sticky);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_one_by_one_half();
    int lat;
    applyStimulus(24'h800000, 24'hC00000);
    waitDone(lat);
    checks++;
    if (lat !== 26 || quotient !== 26'h1555555) begin
      failures++;
      $display("[TB] FAIL result_1_1p5: got lat=%0d q=%h want lat=26 q=1555555", lat, quotient);
    end
    checks++;
    if (sticky !== STICKY_THIRD) begin
      failures++;
      $display("[TB] FAIL sticky_1_1p5: got %b want %b", sticky, STICKY_THIRD);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_div_zero();
    int lat;
    applyStimulus(24'h800000, 24'h000000);
    waitDone(lat);
    checks++;
    if (lat !== 0) begin
      failures++;
      $display("[TB] FAIL latency_divzero: got %0d want 0 edges after start", lat);
    end
    checks++;
    if (quotient !== 26'h3FFFFFF || sticky !== 1'b0 || divZero !== 1'b1) begin
      failures++;
      $display("[TB] FAIL result_divzero: got q=%h st=%b dz=%b want q=3ffffff st=0 dz=1",
               quotient, sticky, divZero);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL divzero_return_idle: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    applyStimulus(24'hC00000, 24'h800000);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin
        dividend = 24'h800000;
        divisor  = 24'hC00000;
        start    = 1'b1;
      end
      if (i == 6) begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (lat !== 26 || quotient !== 26'h3000000 || sticky !== 1'b0 || divZero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL start_ignored: got lat=%0d q=%h st=%b dz=%b want lat=26 q=3000000 st=0 dz=0",
               lat, quotient, sticky, divZero);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midrun();
    int lat;
    int sawDone;
    applyStimulus(24'h800000, 24'h800000);
    repeat (9) @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, sticky, divZero} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_midrun: got busy=%b done=%b q=%h st=%b dz=%b want all zero",
               busy, done, quotient, sticky, divZero);
    end
    @(negedge clk);
    @(negedge clk);
    rstN    = 1'b1;
    sawDone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) sawDone++;
    end
    checks++;
    if (sawDone !== 0) begin
      failures++;
      $display("[TB] FAIL abandoned_op: got %0d busy/done cycles want 0", sawDone);
    end
    applyStimulus(24'h800000, 24'h800000);
    waitDone(lat);
    checks++;
    if (lat !== 26 || quotient !== 26'h2000000 || sticky !== 1'b0) begin
      failures++;
      $display("[TB] FAIL after_reset_1_1: got lat=%0d q=%h st=%b want lat=26 q=2000000 st=0",
               lat, quotient, sticky);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    applyStimulus(24'hC00000, 24'h800000);
    waitDone(lat);
    @(posedge clk);
    #1;
    applyStimulus(24'h800000, 24'hC00000);
    waitDone(lat);
    checks++;
    if (lat !== 26 || quotient !== 26'h1555555 || sticky !== STICKY_THIRD) begin
      failures++;
      $display("[TB] FAIL back_to_back: got lat=%0d q=%h st=%b want lat=26 q=1555555 st=%b",
               lat, quotient, sticky, STICKY_THIRD);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    rstN     = 1'b1;
    #1;
    test_reset();
    test_one_by_one();
    test_one_half_by_one();
    test_one_by_one_half();
    test_div_zero();
    test_start_ignored();
    test_reset_midrun();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
